mitchell_mul_pipe: RTL and testbench
====================================

Name: mitchell_mul_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed-width 8x8 approximate combinational multipliers.
- Takes unsigned W-bit operands and produces a 2W-bit product.
- Product is exact or Mitchell logarithmic approximation, selectable per transaction.
- Three register stages with valid/ready handshake on both sides. Sits in the datapath ahead of the ETM accumulation logic.

Parameters:
- W, 8, operand width in bits (range 4..32); product width 2W.
- LW, $clog2(W), width of leading-one index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- in_mode  in  1  0 = exact product, 1 = Mitchell approximation.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_p  out  2W  product.
- out_mode  out  1  mode the product was computed with.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: on a clk edge with rst_n=0, all stage valid bits clear and out_p=0, out_mode=0, out_valid=0. Reset mid-operation discards all in-flight transactions. in_ready=1 in the first cycle after reset.
- Pipeline advance:
  - Global advance enable en = !out_valid | out_ready.
  - in_ready = en, combinational. No combinational path from in_* to out_*.
  - Transfer occurs on a clk edge with in_valid & in_ready. When en=1, every stage (including its valid bit) shifts forward one slot.
  - Bubbles are not collapsed.
- Latency: exactly 3 cycles with no stall. An operand accepted at edge t appears on out_p with out_valid=1 after edge t+3.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stall: while out_valid & !out_ready, all stage registers and outputs hold unchanged. Data is never dropped or duplicated, and order is preserved.
- Stage 1: register operands and mode. Compute ka = index of the MSB '1' of a, and kb likewise. Compute fractions Fa = (a - 2^ka) << (W-1-ka) and Fb likewise, each W-1 bits. Set flag z = (a==0) | (b==0).
- Stage 2:
  - Mitchell path: S = Fa + Fb (W bits), k = ka + kb.
  - Exact path: partial product of the registered operands, any internal split allowed, result 2W bits.
- Stage 3, Mitchell path:
  - If S < 2^(W-1): P = ((2^(W-1) + S) << k) >> (W-1).
  - Else: P = (S << (k+1)) >> (W-1).
  - Shifts are performed in a 3W-bit intermediate and truncated (floor) to 2W bits. No rounding.
- Stage 3, both paths: if z, P = 0 in both modes. Exact mode gives P = a*b.
- Mitchell result bound: never exceeds a*b and never overflows 2W bits.
- out_mode travels with its data.

Optional Feature:
- Macro: MITCHELL_MUL_ERRSTAT_EN.
- When defined, two additional output ports are added:
  - err_cnt  out  32  number of Mitchell-mode products transferred on the output (out_valid & out_ready & out_mode).
  - err_sum  out  32  running sum of (a*b - P) over those transfers.
- Both counters saturate at 2^32-1, update on the transfer edge, and reset to 0 on rst_n=0.
- Requires the exact product to be computed in Mitchell mode as well.
- When undefined: ports absent, no exact product computed in Mitchell mode, and area and behaviour are otherwise identical.

Test Plan:
- W=8, out_ready=1, single transfer a=3, b=3, mode=1 -> out_p=8 exactly 3 cycles later; same operands with mode=0 -> 9.
- W=8, back-to-back a=12,b=10,m=1 then a=255,b=255,m=1 then a=0,b=200,m=1 -> 112, 65024, 0 on consecutive cycles, out_mode=1 each.
- W=8, 10 random transfers streaming with out_ready held low for cycles 4-7 -> in_ready low during the stall, outputs stable, all 10 products delivered in order with none lost.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0 and out_p=0 next cycle, no stale product emitted afterwards.
- W=16 exhaustive-random 10k vectors, both modes -> exact matches a*b; Mitchell matches the floor formula bit-exactly and never exceeds a*b.
- With MITCHELL_MUL_ERRSTAT_EN: W=8, products (3,3,m1),(12,10,m1),(5,5,m0) -> err_cnt=2, err_sum=9.

Source files
------------

// File: rtl/mitchell_mul_pipe.sv
// mitchell_mul_pipe: pipelined unsigned W x W -> 2W multiplier, exact or
// Mitchell logarithmic approximation selected per transaction.
//
// Pipeline ranks (latency 3 edges from acceptance to out_p):
//   s0  : registered operands and mode
//   s1  : leading-one indices ka/kb, fractions fa/fb, zero flag
//   s2  : mantissa sum S, exponent k, exact partial product
//   out : final product, mode, valid
// All ranks advance together on en = !out_valid | out_ready; bubbles are
// kept, so a stall freezes every rank.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready = en, combinational)
//   in_a, in_b, in_mode   operands (unsigned) and mode (1 = Mitchell)
//   out_valid/out_ready   product handshake
//   out_p, out_mode       product (2W bits) and the mode it was computed in
//   err_cnt, err_sum      only with MITCHELL_MUL_ERRSTAT_EN: count of
//                         Mitchell products delivered and saturating sum of
//                         (a*b - P) over them
//
// Optional feature macro: MITCHELL_MUL_ERRSTAT_EN.
module mitchell_mul_pipe #(
    parameter int unsigned W  = 8,
    parameter int unsigned LW = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             out_mode
`ifdef MITCHELL_MUL_ERRSTAT_EN
    ,
    output logic [31:0]      err_cnt,
    output logic [31:0]      err_sum
`endif
);

    localparam int unsigned PW = 2 * W;          // product width
    localparam int unsigned XW = 3 * W;          // shift intermediate width
    localparam int unsigned KW = LW + 1;         // exponent sum width
    localparam int unsigned FW = W - 1;          // fraction width
`ifdef MITCHELL_MUL_ERRSTAT_EN
    localparam int unsigned SW = ((PW > 32) ? PW : 32) + 1;  // sum + carry
`endif

    // Index of the most significant set bit (0 for v == 0).
    function automatic logic [LW-1:0] lead_one(input logic [W-1:0] v);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) idx = LW'(i);
        end
        return idx;
    endfunction

    // Bits below the leading one, left-aligned into FW bits.
    function automatic logic [FW-1:0] frac_of(input logic [W-1:0] v,
                                              input logic [LW-1:0] k);
        logic [W-1:0] rem;
        logic [W-1:0] sh;
        rem = v & ~(W'(1) << k);
        sh  = rem << (LW'(W - 1) - k);
        return sh[FW-1:0];
    endfunction

    // ---------------- state ----------------
    logic            s0_valid_q, s0_valid_d;
    logic [W-1:0]    s0_a_q, s0_a_d;
    logic [W-1:0]    s0_b_q, s0_b_d;
    logic            s0_mode_q, s0_mode_d;

    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_b_q, s1_b_d;
    logic            s1_mode_q, s1_mode_d;
    logic            s1_z_q, s1_z_d;
    logic [LW-1:0]   s1_ka_q, s1_ka_d;
    logic [LW-1:0]   s1_kb_q, s1_kb_d;
    logic [FW-1:0]   s1_fa_q, s1_fa_d;
    logic [FW-1:0]   s1_fb_q, s1_fb_d;

    logic            s2_valid_q, s2_valid_d;
    logic            s2_mode_q, s2_mode_d;
    logic            s2_z_q, s2_z_d;
    logic [W-1:0]    s2_s_q, s2_s_d;
    logic [KW-1:0]   s2_k_q, s2_k_d;
    logic [PW-1:0]   s2_exact_q, s2_exact_d;

    logic            out_valid_q, out_valid_d;
    logic            out_mode_q, out_mode_d;
    logic [PW-1:0]   out_p_q, out_p_d;

`ifdef MITCHELL_MUL_ERRSTAT_EN
    logic [PW-1:0]   out_exact_q, out_exact_d;
    logic [31:0]     err_cnt_q, err_cnt_d;
    logic [31:0]     err_sum_q, err_sum_d;
    logic [PW-1:0]   diff_c;
    logic [SW-1:0]   sum_c;
    logic            err_xfer_c;
`endif

    // ---------------- combinational datapath ----------------
    logic            en_c;
    logic [LW-1:0]   ka_c, kb_c;
    logic [FW-1:0]   fa_c, fb_c;
    logic [W-1:0]    mul_a_c, mul_b_c;
    logic [PW-1:0]   exact_c;
    logic [XW-1:0]   half_c, mant_c, shifted_c;
    logic [PW-1:0]   mitch_c, p_c;

    assign en_c     = !out_valid_q || out_ready;
    assign in_ready = en_c;

    // Stage 1: leading-one detection and fraction extraction.
    always_comb begin
        ka_c = lead_one(s0_a_q);
        kb_c = lead_one(s0_b_q);
        fa_c = frac_of(s0_a_q, ka_c);
        fb_c = frac_of(s0_b_q, kb_c);
    end

    // Stage 2: exact product; without error statistics the multiplier
    // inputs are held at zero for Mitchell transactions.
    always_comb begin
`ifdef MITCHELL_MUL_ERRSTAT_EN
        mul_a_c = s1_a_q;
        mul_b_c = s1_b_q;
`else
        mul_a_c = s1_mode_q ? '0 : s1_a_q;
        mul_b_c = s1_mode_q ? '0 : s1_b_q;
`endif
        exact_c = PW'(mul_a_c) * PW'(mul_b_c);
    end

    // Stage 3: antilog. S[W-1] set means S >= 2^(W-1) (mantissa carried).
    always_comb begin
        half_c = XW'(1) << (W - 1);
        if (!s2_s_q[W-1]) begin
            mant_c = (half_c + XW'(s2_s_q)) << s2_k_q;
        end else begin
            mant_c = XW'(s2_s_q) << (s2_k_q + KW'(1));
        end
        shifted_c = mant_c >> (W - 1);
        mitch_c   = shifted_c[PW-1:0];
        if (s2_z_q) begin
            p_c = '0;
        end else if (s2_mode_q) begin
            p_c = mitch_c;
        end else begin
            p_c = s2_exact_q;
        end
    end

    // Next-state: every rank holds unless the pipeline advances.
    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_a_d      = s0_a_q;
        s0_b_d      = s0_b_q;
        s0_mode_d   = s0_mode_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        s1_z_d      = s1_z_q;
        s1_ka_d     = s1_ka_q;
        s1_kb_d     = s1_kb_q;
        s1_fa_d     = s1_fa_q;
        s1_fb_d     = s1_fb_q;
        s2_valid_d  = s2_valid_q;
        s2_mode_d   = s2_mode_q;
        s2_z_d      = s2_z_q;
        s2_s_d      = s2_s_q;
        s2_k_d      = s2_k_q;
        s2_exact_d  = s2_exact_q;
        out_valid_d = out_valid_q;
        out_mode_d  = out_mode_q;
        out_p_d     = out_p_q;
`ifdef MITCHELL_MUL_ERRSTAT_EN
        out_exact_d = out_exact_q;
`endif
        if (en_c) begin
            s0_valid_d  = in_valid;
            s0_a_d      = in_a;
            s0_b_d      = in_b;
            s0_mode_d   = in_mode;

            s1_valid_d  = s0_valid_q;
            s1_a_d      = s0_a_q;
            s1_b_d      = s0_b_q;
            s1_mode_d   = s0_mode_q;
            s1_z_d      = (s0_a_q == '0) || (s0_b_q == '0);
            s1_ka_d     = ka_c;
            s1_kb_d     = kb_c;
            s1_fa_d     = fa_c;
            s1_fb_d     = fb_c;

            s2_valid_d  = s1_valid_q;
            s2_mode_d   = s1_mode_q;
            s2_z_d      = s1_z_q;
            s2_s_d      = W'(s1_fa_q) + W'(s1_fb_q);
            s2_k_d      = KW'(s1_ka_q) + KW'(s1_kb_q);
            s2_exact_d  = exact_c;

            out_valid_d = s2_valid_q;
            out_mode_d  = s2_mode_q;
            out_p_d     = p_c;
`ifdef MITCHELL_MUL_ERRSTAT_EN
            out_exact_d = s2_exact_q;
`endif
        end
    end

`ifdef MITCHELL_MUL_ERRSTAT_EN
    // Saturating error statistics over delivered Mitchell products.
    always_comb begin
        err_xfer_c = out_valid_q && out_ready && out_mode_q;
        diff_c     = out_exact_q - out_p_q;
        sum_c      = SW'(err_sum_q) + SW'(diff_c);
        err_cnt_d  = err_cnt_q;
        err_sum_d  = err_sum_q;
        if (err_xfer_c) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
            err_sum_d = (|sum_c[SW-1:32]) ? '1 : sum_c[31:0];
        end
    end
`endif

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s0_mode_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= 1'b0;
            s1_z_q      <= 1'b0;
            s1_ka_q     <= '0;
            s1_kb_q     <= '0;
            s1_fa_q     <= '0;
            s1_fb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_z_q      <= 1'b0;
            s2_s_q      <= '0;
            s2_k_q      <= '0;
            s2_exact_q  <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_p_q     <= '0;
`ifdef MITCHELL_MUL_ERRSTAT_EN
            out_exact_q <= '0;
            err_cnt_q   <= '0;
            err_sum_q   <= '0;
`endif
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_a_q      <= s0_a_d;
            s0_b_q      <= s0_b_d;
            s0_mode_q   <= s0_mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s1_z_q      <= s1_z_d;
            s1_ka_q     <= s1_ka_d;
            s1_kb_q     <= s1_kb_d;
            s1_fa_q     <= s1_fa_d;
            s1_fb_q     <= s1_fb_d;
            s2_valid_q  <= s2_valid_d;
            s2_mode_q   <= s2_mode_d;
            s2_z_q      <= s2_z_d;
            s2_s_q      <= s2_s_d;
            s2_k_q      <= s2_k_d;
            s2_exact_q  <= s2_exact_d;
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            out_p_q     <= out_p_d;
`ifdef MITCHELL_MUL_ERRSTAT_EN
            out_exact_q <= out_exact_d;
            err_cnt_q   <= err_cnt_d;
            err_sum_q   <= err_sum_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_p     = out_p_q;
`ifdef MITCHELL_MUL_ERRSTAT_EN
    assign err_cnt   = err_cnt_q;
    assign err_sum   = err_sum_q;
`endif

endmodule

// File: tb/tb_mitchell_mul_pipe.sv
// Bench for mitchell_mul_pipe: a W=8 instance for directed latency, stall,
// reset and statistics cases, and a W=16 instance for a long randomised run.
// Expected products come from an arithmetic reference model and scoreboards.
module tb_mitchell_mul_pipe;

    typedef struct {
        longint unsigned p;
        longint unsigned exact;
        bit              mode;
    } item_t;

    logic clk;
    logic rst_n;

    logic        iv8, ir8, m8, ov8, ordy8, om8;
    logic [7:0]  a8, b8;
    logic [15:0] op8;
    logic        iv16, ir16, m16, ov16, ordy16, om16;
    logic [15:0] a16, b16;
    logic [31:0] op16;
`ifdef MITCHELL_MUL_ERRSTAT_EN
    logic [31:0] ec8, es8, ec16, es16;
    longint unsigned mcnt16, msum16;
`endif

    item_t q8[$];
    item_t q16[$];
    item_t it8, it16;
    int    n_checks, n_errors, n_out8;

    mitchell_mul_pipe #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_mode(m8),
        .out_valid(ov8), .out_ready(ordy8), .out_p(op8), .out_mode(om8)
`ifdef MITCHELL_MUL_ERRSTAT_EN
        , .err_cnt(ec8), .err_sum(es8)
`endif
    );

    mitchell_mul_pipe #(.W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_mode(m16),
        .out_valid(ov16), .out_ready(ordy16), .out_p(op16), .out_mode(om16)
`ifdef MITCHELL_MUL_ERRSTAT_EN
        , .err_cnt(ec16), .err_sum(es16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor(log2) exponents, left-aligned fractions, antilog.
    function automatic longint unsigned ref_mul(longint unsigned a, longint unsigned b,
                                                bit m, int w);
        longint unsigned fa, fb, s, half, mant;
        int ka, kb;
        if (a == 0 || b == 0) return 0;
        if (!m) return a * b;
        ka = 0;
        while ((a >> (ka + 1)) != 0) ka++;
        kb = 0;
        while ((b >> (kb + 1)) != 0) kb++;
        fa   = (a - (64'd1 << ka)) << (w - 1 - ka);
        fb   = (b - (64'd1 << kb)) << (w - 1 - kb);
        half = 64'd1 << (w - 1);
        s    = fa + fb;
        if (s < half) mant = (half + s) << (ka + kb);
        else          mant = s << (ka + kb + 1);
        return (mant >> (w - 1)) & ((64'd1 << (2 * w)) - 1);
    endfunction

    function automatic item_t mk(longint unsigned a, longint unsigned b, bit m, int w);
        item_t it;
        it.exact = a * b;
        it.p     = ref_mul(a, b, m, w);
        it.mode  = m;
        return it;
    endfunction

    function automatic logic [15:0] gen16();
        int r;
        r = $urandom % 8;
        if (r == 0) return 16'd0;
        if (r == 1) return 16'hFFFF;
        if (r == 2) return 16'(32'd1 << ($urandom % 16));
        return 16'($urandom);
    endfunction

    // Scoreboards: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8 && ordy8) begin
                if (q8.size() == 0) begin
                    check("dut8_spurious_out", 1, 0);
                end else begin
                    it8 = q8.pop_front();
                    check("dut8_p", op8, it8.p);
                    check("dut8_mode", om8, it8.mode);
                    n_out8++;
                end
            end
            if (iv8 && ir8) q8.push_back(mk(a8, b8, m8, 8));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov16 && ordy16) begin
                if (q16.size() == 0) begin
                    check("dut16_spurious_out", 1, 0);
                end else begin
                    it16 = q16.pop_front();
                    check("dut16_p", op16, it16.p);
                    check("dut16_mode", om16, it16.mode);
                    if (it16.mode) check("dut16_bound", op16 <= it16.exact, 1);
`ifdef MITCHELL_MUL_ERRSTAT_EN
                    if (it16.mode) begin
                        if (mcnt16 < 64'hFFFFFFFF) mcnt16++;
                        msum16 = msum16 + (it16.exact - it16.p);
                        if (msum16 > 64'hFFFFFFFF) msum16 = 64'hFFFFFFFF;
                    end
`endif
                end
            end
            if (iv16 && ir16) q16.push_back(mk(a16, b16, m16, 16));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iv8   = 1'b0;
        iv16  = 1'b0;
        q8.delete();
        q16.delete();
`ifdef MITCHELL_MUL_ERRSTAT_EN
        mcnt16 = 0;
        msum16 = 0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain8(input string tag);
        for (int c = 0; c < 50 && q8.size() != 0; c++) tick();
        check(tag, q8.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        int         sent, cyc, n_acc, out_before;
        logic       acc;

        n_checks = 0; n_errors = 0; n_out8 = 0;
        a8 = '0; b8 = '0; m8 = 1'b0; ordy8 = 1'b1;
        a16 = '0; b16 = '0; m16 = 1'b0; ordy16 = 1'b1;
        iv8 = 1'b0; iv16 = 1'b0;
        do_reset();

        // Reset state
        check("reset_out_valid", ov8, 0);
        check("reset_out_p", op8, 0);
        check("reset_out_mode", om8, 0);
        check("reset_in_ready", ir8, 1);

        // Single transfer 3x3, Mitchell then exact, with latency check
        for (int i = 0; i < 2; i++) begin
            a8 = 8'd3; b8 = 8'd3; m8 = (i == 0); iv8 = 1'b1;
            tick();
            iv8 = 1'b0;
            for (int c = 0; c < 3; c++) begin
                check("latency_early_valid", ov8, 0);
                tick();
            end
            check("latency_valid", ov8, 1);
            check("single_3x3_p", op8, (i == 0) ? 8 : 9);
            check("single_3x3_mode", om8, (i == 0) ? 1 : 0);
            tick();
            check("single_no_dup", ov8, 0);
        end

        // Back-to-back Mitchell products
        ta[0] = 8'd12;  tb[0] = 8'd10;
        ta[1] = 8'd255; tb[1] = 8'd255;
        ta[2] = 8'd0;   tb[2] = 8'd200;
        for (int i = 0; i < 3; i++) begin
            a8 = ta[i]; b8 = tb[i]; m8 = 1'b1; iv8 = 1'b1;
            tick();
        end
        iv8 = 1'b0;
        tick();
        check("b2b_0_valid", ov8, 1); check("b2b_0_p", op8, 112);   check("b2b_0_mode", om8, 1);
        tick();
        check("b2b_1_valid", ov8, 1); check("b2b_1_p", op8, 65024); check("b2b_1_mode", om8, 1);
        tick();
        check("b2b_2_valid", ov8, 1); check("b2b_2_p", op8, 0);     check("b2b_2_mode", om8, 1);
        tick();

        // 10 random transfers with out_ready low in cycles 4..7
        out_before = n_out8;
        sent = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
        for (int c = 0; c < 100 && sent < 10; c++) begin
            ordy8 = !(c >= 4 && c <= 7);
            iv8   = 1'b1;
            #1;
            if (c >= 4 && c <= 7) begin
                check("stall_in_ready", ir8, 0);
                check("stall_out_valid", ov8, 1);
                check("stall_out_p_head", op8, q8[0].p);
            end
            acc = iv8 && ir8;
            tick();
            if (acc) begin
                sent++;
                a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
            end
        end
        iv8 = 1'b0; ordy8 = 1'b1;
        check("stall_sent", sent, 10);
        drain8("stall_drain");
        check("stall_delivered", n_out8 - out_before, 10);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom | 1); b8 = 8'($urandom | 1); m8 = 1'($urandom); iv8 = 1'b1;
            tick();
        end
        iv8 = 1'b0;
        rst_n = 1'b0;
        q8.delete();
        tick();
        rst_n = 1'b1;
        check("midreset_out_valid", ov8, 0);
        check("midreset_out_p", op8, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midreset_no_stale", ov8, 0);
        end

`ifdef MITCHELL_MUL_ERRSTAT_EN
        // Error statistics over (3,3,m1),(12,10,m1),(5,5,m0)
        do_reset();
        check("errstat_reset_cnt", ec8, 0);
        check("errstat_reset_sum", es8, 0);
        a8 = 8'd3;  b8 = 8'd3;  m8 = 1'b1; iv8 = 1'b1; tick();
        a8 = 8'd12; b8 = 8'd10; m8 = 1'b1; tick();
        a8 = 8'd5;  b8 = 8'd5;  m8 = 1'b0; tick();
        iv8 = 1'b0;
        drain8("errstat_drain");
        tick();
        check("errstat_cnt", ec8, 2);
        check("errstat_sum", es8, 9);
`endif

        // W=16 randomised run with random backpressure, both modes
        do_reset();
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            iv16   = ($urandom % 5) != 0;
            ordy16 = ($urandom % 4) != 0;
            a16    = gen16();
            b16    = gen16();
            m16    = 1'($urandom);
            #1;
            if (iv16 && ir16) n_acc++;
            tick();
            cyc++;
        end
        iv16 = 1'b0; ordy16 = 1'b1;
        check("rand16_accepted", n_acc, 10000);
        for (int c = 0; c < 50 && q16.size() != 0; c++) tick();
        check("rand16_drain", q16.size(), 0);
`ifdef MITCHELL_MUL_ERRSTAT_EN
        tick();
        check("rand16_err_cnt", ec16, mcnt16);
        check("rand16_err_sum", es16, msum16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
